clk_div_bank: RTL

Parametrised bank of NUM_CH independent integer clock dividers, all running off clk_50. Each channel has a runtime-programmable divisor and produces two outputs: a near-50% duty divided clock, and a single-cycle clock-enable strobe aligned to that clock's rising edge. Divisor changes are glitch-free because they are applied only at period boundaries. The bank sits at the top of the VGA path and supplies the pixel clock/enable (e.g. 25 MHz) plus auxiliary slower ticks.

---
 rtl/clk_div_bank.sv | 129 ++++++++++++
 1 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank: a bank of NUM_CH independent integer clock dividers on clk_50.
// Each channel produces a registered near-50% divided clock (clk_out) and a
// one-cycle enable strobe (clk_en) coincident with that clock's rising edge.
// New divisors land in a per-channel shadow register and are promoted to the
// active divisor only at a period boundary, or at once while the channel is
// stopped, so the divided clock never produces a runt phase.
//
// Write port semantics: div_wr is a single-cycle strobe with no ready. Every
// cycle with div_wr=1 is consumed. It updates shadow[div_sel] and raises
// pending[div_sel] only if div_sel addresses an existing channel and div_val
// is nonzero. Otherwise the write is dropped without any state change.
module clk_div_bank #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int SEL_W       = 4
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [DIV_W-1:0]  div_val,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);
  localparam logic [DIV_W-1:0] DEF_D = DIV_W'(DEFAULT_DIV);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [SEL_W-1:0] CH_IDX = SEL_W'(i);

    // Registered channel state
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] d_q;
    logic [DIV_W-1:0] shadow_q;
    logic             pend_q;
    logic             out_q;
    logic             en_q;

    // Next-state values
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] d_nxt;
    logic [DIV_W-1:0] shadow_nxt;
    logic [DIV_W-1:0] half_nxt;
    logic             pend_nxt;
    logic             out_nxt;
    logic             en_nxt;
    logic             wr_hit;
    logic             boundary;
    logic             apply;

    // A write for this channel is honoured only when it carries a nonzero divisor.
    assign wr_hit   = div_wr && (div_sel == CH_IDX) && (div_val != '0);
    // Last cycle of the current period for the active divisor.
    assign boundary = (cnt_q == (d_q - ONE_D));

    // Next-state logic: counter, divisor promotion and output decode.
    always_comb begin
      cnt_nxt    = '0;
      d_nxt      = d_q;
      shadow_nxt = shadow_q;
      pend_nxt   = pend_q;
      out_nxt    = 1'b0;
      en_nxt     = 1'b0;
      apply      = 1'b0;
      half_nxt   = '0;

      // A stopped channel takes its pending divisor at once; a running one
      // waits for the period boundary. Only the registered pending flag
      // counts, so a write in the boundary cycle waits a full old period.
      if (ch_en[i]) begin
        apply = boundary && pend_q;
      end else begin
        apply = pend_q;
      end

      if (apply) begin
        d_nxt    = shadow_q;
        pend_nxt = 1'b0;
      end

      // A fresh write outranks the clear from a simultaneous apply.
      if (wr_hit) begin
        shadow_nxt = div_val;
        pend_nxt   = 1'b1;
      end

      if (ch_en[i] && !boundary) begin
        cnt_nxt = cnt_q + ONE_D;
      end else begin
        cnt_nxt = '0;
      end

      // The first phase of a new period is decoded with the new divisor.
      half_nxt = d_nxt >> 1;
      if (ch_en[i]) begin
        out_nxt = (cnt_nxt >= half_nxt);
        en_nxt  = (cnt_nxt == half_nxt);
      end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_50) begin
      if (!reset_n) begin
        cnt_q    <= '0;
        d_q      <= DEF_D;
        shadow_q <= DEF_D;
        pend_q   <= 1'b0;
        out_q    <= 1'b0;
        en_q     <= 1'b0;
      end else begin
        cnt_q    <= cnt_nxt;
        d_q      <= d_nxt;
        shadow_q <= shadow_nxt;
        pend_q   <= pend_nxt;
        out_q    <= out_nxt;
        en_q     <= en_nxt;
      end
    end

    assign clk_out[i] = out_q;
    assign clk_en[i]  = en_q;
    assign pending[i] = pend_q;
  end

endmodule
